// File: rtl/adder_pkg.sv
// Shared definitions for the registered adder/subtractor datapath.
package adder_pkg;

   localparam int ADDER_WIDTH_DEFAULT = 32;

   // Widest operand the result struct can carry; narrower instances use the
   // low bits of sum and leave the rest zero.
   localparam int ADDER_WIDTH_MAX = 64;

   typedef struct packed {
      logic [ADDER_WIDTH_MAX-1:0] sum;
      logic                       carry;
      logic                       overflow;
   } adder_res_t;

endpackage

// File: rtl/adder_comb.sv
// Purely combinational add/subtract with carry-out and signed overflow.
module adder_comb
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output adder_res_t       res
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   total;

   // Subtraction is a + ~b + 1, so the carry-out doubles as an inverted borrow.
   always_comb begin
      b_eff = sub ? ~b : b;
      total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      res = '0;
      res.sum[WIDTH-1:0] = total[WIDTH-1:0];
      res.carry = total[WIDTH];
      res.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (total[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/adder_core.sv
// Registered adder/subtractor with a single-entry valid/ready output stage.
module adder_core
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   adder_res_t next_res;
   logic       accept;
   logic       transfer;

   adder_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .a   (a),
      .b   (b),
      .sub (sub),
      .res (next_res)
   );

   // The struct is sized for the widest instance; bits above WIDTH are always zero.
   generate
      if (WIDTH < ADDER_WIDTH_MAX) begin : g_sum_hi
         logic unused_sum_hi;
         assign unused_sum_hi = |next_res.sum[ADDER_WIDTH_MAX-1:WIDTH];
      end
   endgenerate

   // The register can take a new result whenever it is empty or being drained.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign transfer = out_valid && out_ready;

   // Output register: new result wins over a drain, otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         sum       <= next_res.sum[WIDTH-1:0];
         carry     <= next_res.carry;
         overflow  <= next_res.overflow;
      end else if (transfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_core.sv
// Scoreboard testbench for adder_core at the default 32-bit width.
module tb_adder_core;

   typedef struct packed {
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        carry;
   logic        overflow;

   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   adder_core #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Reference arithmetic built from plain unsigned/signed math, not the adder formula.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
      exp_t        e;
      logic [32:0] t;
      longint      sx;
      longint      sy;
      longint      sr;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (s) begin
         e.sum   = x - y;
         e.carry = (x >= y);
         sr      = sx - sy;
      end else begin
         t       = {1'b0, x} + {1'b0, y};
         e.sum   = t[31:0];
         e.carry = t[32];
         sr      = sx + sy;
      end
      e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      step();
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      total++;
      if ({sum, carry, overflow} !== 34'h0) begin
         bad++;
         $display("[TB] FAIL reset_fields: got sum=%h c=%b o=%b expected all 0", sum, carry, overflow);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      exp_t e;
      a = 32'd10;
      b = 32'd20;
      sub = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      q.push_back(model(a, b, sub));
      step();
      in_valid = 1'b0;
      a = 32'hDEADBEEF;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_valid: got %b expected 1", out_valid);
      end
      e = q.pop_front();
      total++;
      if ({sum, carry, overflow} !== {e.sum, e.carry, e.ovf}) begin
         bad++;
         $display("[TB] FAIL basic_result: got %h/%b/%b expected %h/%b/%b",
                  sum, carry, overflow, e.sum, e.carry, e.ovf);
      end
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_drain: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va[9];
      logic [31:0] vb[9];
      logic        vs[9];
      exp_t        e;
      va = '{32'd100, 32'd1234, 32'hFFFFFFFB, 32'h7FFFFFFF, 32'hFFFFFFFF,
             32'd5, 32'd7, 32'd0, 32'h80000000};
      vb = '{32'd50, 32'd4321, 32'd15, 32'd1, 32'd1,
             32'd7, 32'd5, 32'h80000000, 32'd1};
      vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = va[0];
      b = vb[0];
      sub = vs[0];
      q.push_back(model(a, b, sub));
      step();
      for (int i = 0; i < 9; i++) begin
         total++;
         if (out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid);
         end
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("[TB] FAIL b2b_queue[%0d]: got empty expected entry", i);
         end else begin
            e = q.pop_front();
            if ({sum, carry, overflow} !== {e.sum, e.carry, e.ovf}) begin
               bad++;
               $display("[TB] FAIL b2b_result[%0d]: got %h/%b/%b expected %h/%b/%b",
                        i, sum, carry, overflow, e.sum, e.carry, e.ovf);
            end
         end
         if (i < 8) begin
            a = va[i+1];
            b = vb[i+1];
            sub = vs[i+1];
            q.push_back(model(a, b, sub));
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      a = 32'd3;
      b = 32'd4;
      sub = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b0;
      q.push_back(model(a, b, sub));
      step();
      a = 32'd100;
      b = 32'd200;
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({in_ready, out_valid} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL bp_handshake[%0d]: got in_ready=%b out_valid=%b expected 0/1",
                     i, in_ready, out_valid);
         end
         e = q[0];
         total++;
         if ({sum, carry, overflow} !== {e.sum, e.carry, e.ovf}) begin
            bad++;
            $display("[TB] FAIL bp_hold[%0d]: got %h/%b/%b expected %h/%b/%b",
                     i, sum, carry, overflow, e.sum, e.carry, e.ovf);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready);
      end
      void'(q.pop_front());
      q.push_back(model(a, b, sub));
      step();
      in_valid = 1'b0;
      e = q.pop_front();
      total++;
      if ({out_valid, sum, carry, overflow} !== {1'b1, e.sum, e.carry, e.ovf}) begin
         bad++;
         $display("[TB] FAIL bp_replace: got v=%b %h/%b/%b expected v=1 %h/%b/%b",
                  out_valid, sum, carry, overflow, e.sum, e.carry, e.ovf);
      end
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_drain: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_random();
      logic mv;
      logic exp_ready;
      exp_t e;
      mv = 1'b0;
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         a = $urandom;
         b = $urandom;
         sub = $urandom_range(0, 1);
         if ($urandom_range(0, 4) == 0) a = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
         if ($urandom_range(0, 4) == 0) b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
         #1;
         exp_ready = !mv || out_ready;
         total++;
         if (in_ready !== exp_ready) begin
            bad++;
            $display("[TB] FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, exp_ready);
         end
         total++;
         if (out_valid !== mv) begin
            bad++;
            $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, mv);
         end
         if (mv) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("[TB] FAIL rnd_queue[%0d]: got empty expected entry", i);
            end else begin
               e = q[0];
               if ({sum, carry, overflow} !== {e.sum, e.carry, e.ovf}) begin
                  bad++;
                  $display("[TB] FAIL rnd_result[%0d]: got %h/%b/%b expected %h/%b/%b",
                           i, sum, carry, overflow, e.sum, e.carry, e.ovf);
               end
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && exp_ready) begin
            q.push_back(model(a, b, sub));
            mv = 1'b1;
         end else if (mv && out_ready) begin
            mv = 1'b0;
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      q.delete();
   endtask

   task automatic test_reset_mid();
      a = 32'hFFFFFFFF;
      b = 32'h80000000;
      sub = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      total++;
      if ({out_valid, sum, carry, overflow} !== {1'b1, 32'h7FFFFFFF, 1'b1, 1'b1}) begin
         bad++;
         $display("[TB] FAIL rstmid_loaded: got v=%b %h/%b/%b expected v=1 7fffffff/1/1",
                  out_valid, sum, carry, overflow);
      end
      rst_n = 1'b0;
      a = 32'd1;
      b = 32'd2;
      step();
      total++;
      if ({out_valid, sum, carry, overflow} !== 35'h0) begin
         bad++;
         $display("[TB] FAIL rstmid_clear: got v=%b %h/%b/%b expected all 0",
                  out_valid, sum, carry, overflow);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready);
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adder_core.md
# adder_core

Registered two's-complement adder/subtractor with a valid/ready stream interface and status flags. Accepts one operand pair per accepted transfer and returns the modular sum (or difference), carry-out and signed overflow one cycle later. Serves as the datapath arithmetic primitive behind the `adder` wrapper name: ports `a`, `b`, `sum` keep that naming, and downstream consumers may apply backpressure.

## Interface
- `WIDTH`, default 32: operand and result width in bits (minimum 2).
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: operand pair on `a`/`b`/`sub` is valid.
- `in_ready`  out  1: block can accept the pair this cycle.
- `a`  in  WIDTH: operand A, unsigned or two's complement.
- `b`  in  WIDTH: operand B, unsigned or two's complement.
- `sub`  in  1: 0 = a+b, 1 = a−b.
- `out_valid`  out  1: result fields are valid.
- `out_ready`  in  1: consumer accepts the result this cycle.
- `sum`  out  WIDTH: result modulo 2^WIDTH.
- `carry`  out  1: carry-out of MSB. For `sub`=1 this is the inverted borrow: 1 means no borrow, i.e. a ≥ b unsigned.
- `overflow`  out  1: signed overflow of the operation.

## Operation
- Input accept occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Arithmetic: compute `{carry, sum} = a + (sub ? ~b : b) + sub` in WIDTH+1 bits. Result wraps silently modulo 2^WIDTH.
- Overflow: `overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB])`, where `b_eff` is `b` as presented to the adder (`~b` when `sub`=1).
- The output register holds exactly one result: `sum`, `carry`, `overflow`, `out_valid`.
- `in_ready = !out_valid || out_ready`. This allows full throughput of one result per cycle while the consumer is ready.
- Output register update on each rising edge:
  - On input accept: load the new result and set `out_valid` = 1.
  - Else on output transfer: clear `out_valid` = 0.
  - Otherwise: hold all output fields.
- While `out_valid`=1 and `out_ready`=0, `sum`, `carry` and `overflow` are stable.
- Inputs are ignored when no accept occurs. `a`, `b` and `sub` may change freely while `in_valid`=0.

## Timing
- Latency: exactly 1 cycle. A pair accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: 1 result per cycle when `out_ready` is held at 1.
- Reset (`rst_n`=0 at a rising edge):
  - `out_valid` ← 0; `sum`, `carry`, `overflow` ← 0.
  - `in_ready` is 1 combinationally while `out_valid`=0.
- Reset mid-operation: any held or unconsumed result is discarded. No input is accepted on a reset edge.
- Simultaneous output transfer and input accept in the same cycle: the new result replaces the old one. `out_valid` remains 1.
- No combinational path from `a`/`b`/`sub`/`in_valid` to any output.
- `in_ready` depends combinationally only on `out_valid` and `out_ready`.

## Structure
- Shared package `adder_pkg`:
  - `localparam ADDER_WIDTH_DEFAULT = 32`.
  - Typedef `adder_res_t` struct with fields `sum`, `carry`, `overflow`.
- One sub-module, `adder_comb`: purely combinational `a`, `b`, `sub` → `adder_res_t`.
- The top level contains only the handshake logic and the output register.

## Test plan
- Reset then `sub`=0, a=10, b=20, `out_ready`=1 → one cycle later `sum`=30, `carry`=0, `overflow`=0, `out_valid`=1.
- Back-to-back pairs (100,50), (1234,4321), (0xFFFFFFFB,15) with `sub`=0 → consecutive cycles give 150, 5555, then 10 with `carry`=1, `overflow`=0.
- Overflow boundaries:
  - a=0x7FFFFFFF, b=1, `sub`=0 → `sum`=0x80000000, `overflow`=1, `carry`=0.
  - a=0xFFFFFFFF, b=1 → `sum`=0, `carry`=1, `overflow`=0.
- Subtract: a=5, b=7, `sub`=1 → `sum`=0xFFFFFFFE, `carry`=0, `overflow`=0. a=7, b=5 → `sum`=2, `carry`=1.
- Backpressure: `out_ready`=0 with the result held → `in_ready`=0, outputs stable for 5 cycles. Raising `out_ready` with a new pair present → transfer and accept in the same cycle.
- Assert `rst_n`=0 while `out_valid`=1 and `out_ready`=0 → after the edge, `out_valid`=0, all outputs 0, `in_ready`=1.
